debounce_edge: RTL
==================

# debounce_edge

Conditions a raw, asynchronous, possibly bouncing input (push-button or external strobe) into a clean, clock-synchronous level and single-cycle edge pulses. It sits directly upstream of the D flip-flop stage: `level` drives that stage's D input, and `rise`/`fall` serve as one-shot enables for downstream logic. Internally it is a configurable synchronizer chain followed by a counter-qualified four-state debounce FSM.

## Interface
Parameters:
- `SYNC_STAGES`, default 2: flip-flops in the synchronizer chain. Must be ≥ 2.
- `DEBOUNCE_CYCLES`, default 4: consecutive stable synchronized samples required to accept a new level. Must be ≥ 2.
- `CNT_W`, default `$clog2(DEBOUNCE_CYCLES)+1`: counter width. Derived; do not override.

Ports:
- `clk` input 1: single clock; all state updates on the rising edge.
- `reset` input 1: asynchronous, active-low reset.
- `din` input 1: raw asynchronous input.
- `level` output 1: debounced, synchronized level.
- `rise` output 1: one-cycle pulse on an accepted 0→1 transition.
- `fall` output 1: one-cycle pulse on an accepted 1→0 transition.
- `busy` output 1: high while a candidate transition is being qualified.

## Operation
- The synchronizer chain samples `din`; `s` is the last stage. Only `s` feeds the FSM.
- FSM states: `LOW`, `WAIT_HIGH`, `HIGH`, `WAIT_LOW`.
- `LOW`:
  - `s=1` → `WAIT_HIGH`, `cnt<=1`.
  - Otherwise stay.
- `WAIT_HIGH`:
  - `s=0` → `LOW`, `cnt<=0`. This is a glitch; no pulse.
  - `s=1` and `cnt==DEBOUNCE_CYCLES-1` → `HIGH`, `level<=1`, `rise<=1`, `cnt<=0`.
  - Otherwise `cnt<=cnt+1`.
- `HIGH` and `WAIT_LOW` mirror `LOW` and `WAIT_HIGH` with polarity inverted, `fall` in place of `rise`, and `level<=0` on acceptance.
- `rise` and `fall` are registered, high for exactly one cycle, and never high together.
- `busy` is registered and high exactly when the state is `WAIT_HIGH` or `WAIT_LOW`.
- `cnt` never exceeds `DEBOUNCE_CYCLES-1` and never wraps. Every path out of a WAIT state reloads it.

## Timing
- Reset asserted (`reset=0`), at any time including mid-qualification:
  - State `LOW`, `cnt=0`, all synchronizer stages 0.
  - `level=0`, `rise=0`, `fall=0`, `busy=0`, immediately and asynchronously.
- Acceptance latency: `din` stable high from the clock edge E1 onward gives `level=1` and `rise=1` after edge E(`SYNC_STAGES+DEBOUNCE_CYCLES`). With defaults this is edge 6.
- Falling-transition latency is identical.
- A synchronized excursion shorter than `DEBOUNCE_CYCLES` samples produces no change on `level`, `rise` or `fall`. `busy` pulses for the length of the excursion.
- Raw `din` high while reset is asserted: after reset deasserts, the block follows the normal acceptance path and `rise` pulses once at full latency.
- `s` toggling every cycle: the FSM alternates between the stable state and its WAIT state indefinitely and `level` never changes.
- `din` changes while `level` is already at that value: no action.

## Structure
- Package `debounce_pkg`:
  - Enum `db_state_t` {`LOW`, `WAIT_HIGH`, `HIGH`, `WAIT_LOW`}, 2-bit encoding.
  - Default constants `DB_SYNC_STAGES=2` and `DB_CYCLES=4`.
- Sub-module `sync_chain`:
  - Parameter `STAGES`.
  - Ports `clk`, `reset`, `d`, `q`.
  - All stages reset to 0.
  - Reused elsewhere for any asynchronous input.
- Top-level `debounce_edge` contains the FSM, counter and output registers only.

## Test plan
Common setup: defaults, 20 ns clock, `reset=0` for 100 ns, then `reset=1`.
- Reset and idle: hold `din=0` for 20 cycles → `level`, `rise`, `fall` and `busy` stay 0 throughout.
- Clean rise: `din` 0→1 before edge E1 and held → `level=1` and `rise=1` for exactly one cycle after E6; `busy` high after E3–E5; `rise=0` from E7.
- Glitch rejection: `din` high for 3 cycles, then low → `level` and `rise` never assert; `busy` high for 3 cycles.
- Bounce then settle: from `level=1`, `din` toggles 1,0,1,0,0,0,0,… → exactly one `fall` pulse, at 6 edges after the final 1→0; `level=0` afterwards.
- Reset mid-qualification: assert `reset=0` while `busy=1` during a rise → `busy` and `cnt` clear at once; after release with `din` still high, `rise` fires exactly once at full latency.
- Parameter sweep: `DEBOUNCE_CYCLES=2` and `SYNC_STAGES=3` → rise latency is 5 edges; a 1-sample pulse is rejected.

Source files
------------

// File: rtl/debounce_pkg.sv
// rtl/debounce_pkg.sv - shared state encoding and default parameters for the debouncer
package debounce_pkg;

  typedef enum logic [1:0] {
    LOW       = 2'd0,
    WAIT_HIGH = 2'd1,
    HIGH      = 2'd2,
    WAIT_LOW  = 2'd3
  } db_state_t;

  localparam int DB_SYNC_STAGES = 2;
  localparam int DB_CYCLES      = 4;

endpackage

// File: rtl/debounce_edge_sync_chain.sv
// rtl/debounce_edge_sync_chain.sv - multi-flop synchronizer for an asynchronous input
module sync_chain
  import debounce_pkg::*;
#(
  parameter int STAGES = DB_SYNC_STAGES
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] stages;

  // Shift the raw input through the chain; every stage clears on reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stages <= '0;
    end else begin
      stages <= {stages[STAGES-2:0], d};
    end
  end

  assign q = stages[STAGES-1];

endmodule

// File: rtl/debounce_edge.sv
// rtl/debounce_edge.sv - synchronize and debounce a raw input into a level plus edge pulses
module debounce_edge
  import debounce_pkg::*;
#(
  parameter int SYNC_STAGES     = DB_SYNC_STAGES,
  parameter int DEBOUNCE_CYCLES = DB_CYCLES,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES) + 1
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall,
  output logic busy
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic             s;
  db_state_t        state;
  logic [CNT_W-1:0] cnt;

  sync_chain #(
    .STAGES(SYNC_STAGES)
  ) u_sync (
    .clk  (clk),
    .reset(reset),
    .d    (din),
    .q    (s)
  );

  // Qualify each candidate transition over consecutive stable samples; outputs are registered.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= LOW;
      cnt   <= '0;
      level <= 1'b0;
      rise  <= 1'b0;
      fall  <= 1'b0;
      busy  <= 1'b0;
    end else begin
      rise <= 1'b0;
      fall <= 1'b0;
      case (state)
        LOW: begin
          if (s) begin
            state <= WAIT_HIGH;
            cnt   <= CNT_ONE;
            busy  <= 1'b1;
          end
        end
        WAIT_HIGH: begin
          if (!s) begin
            // Glitch: drop back without touching level or pulsing.
            state <= LOW;
            cnt   <= '0;
            busy  <= 1'b0;
          end else if (cnt == CNT_LAST) begin
            state <= HIGH;
            level <= 1'b1;
            rise  <= 1'b1;
            cnt   <= '0;
            busy  <= 1'b0;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        HIGH: begin
          if (!s) begin
            state <= WAIT_LOW;
            cnt   <= CNT_ONE;
            busy  <= 1'b1;
          end
        end
        WAIT_LOW: begin
          if (s) begin
            state <= HIGH;
            cnt   <= '0;
            busy  <= 1'b0;
          end else if (cnt == CNT_LAST) begin
            state <= LOW;
            level <= 1'b0;
            fall  <= 1'b1;
            cnt   <= '0;
            busy  <= 1'b0;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        default: begin
          state <= LOW;
          cnt   <= '0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
